cursor_select_ctrl: RTL and testbench

//  Input side of the board display interface: turns raw pushbuttons into cursor_loc/select_loc for the
//  VGA renderer and issues move requests (from/to) to the game engine over a valid/ready handshake.

---
 rtl/cursor_select_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_cursor_select_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cursor_select_ctrl.sv
// Pushbutton front end for the board display: debounces six buttons, moves the cursor,
// tracks piece selection and issues move requests to the game engine over valid/ready.
module cursor_select_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          WRAP            = 1'b0,
  parameter logic [5:0]  RESET_CURSOR    = 6'o00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   btn_n,
  input  logic         turn,
  input  logic [191:0] serialized_board,
  input  logic [27:0]  legal_move,
  output logic [5:0]   cursor_loc,
  output logic [5:0]   select_loc,
  output logic         sel_active,
  output logic         move_valid,
  output logic [5:0]   move_from,
  output logic [5:0]   move_to,
  input  logic         move_ready
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_REQUEST  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button bit positions; lower index wins among the cursor moves.
  localparam int B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3, B_SEL = 4, B_CAN = 5;

  function automatic logic own_sq(input logic [191:0] brd, input logic [5:0] c, input logic t);
    logic [7:0] idx;
    idx = {2'b00, c} * 8'd3;
    return brd[idx + 8'd2] && (brd[idx + 8'd1] == t);
  endfunction

  function automatic logic legal_sq(input logic [27:0] lm, input logic [5:0] c);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (lm[7*k+6] && (lm[7*k +: 6] == c)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  function automatic logic [2:0] step_inc(input logic [2:0] v);
    if (v == 3'd7) begin
      return WRAP ? 3'd0 : 3'd7;
    end else begin
      return v + 3'd1;
    end
  endfunction

  function automatic logic [2:0] step_dec(input logic [2:0] v);
    if (v == 3'd0) begin
      return WRAP ? 3'd7 : 3'd0;
    end else begin
      return v - 3'd1;
    end
  endfunction

  logic [5:0]       sync1_q, sync2_q;
  logic [5:0]       lvl_q, lvl_d;
  logic [5:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic [5:0]       ev_s;

  state_e     state_q, state_d;
  logic [5:0] cursor_q, cursor_d;
  logic [5:0] select_loc_q, select_loc_d;
  logic       sel_active_q, sel_active_d;
  logic       move_valid_q, move_valid_d;
  logic [5:0] move_from_q, move_from_d;
  logic [5:0] move_to_q, move_to_d;

  // Debounce: accepted level (1 = pressed) follows the synchronized level after it differs long enough.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      if (~sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = ~sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    press_d = lvl_d & ~lvl_q;
  end

  // Only the highest-priority press of the cycle survives.
  always_comb begin
    ev_s = 6'b000000;
    if (press_q[B_CAN]) begin
      ev_s[B_CAN] = 1'b1;
    end else if (press_q[B_SEL]) begin
      ev_s[B_SEL] = 1'b1;
    end else if (press_q[B_UP]) begin
      ev_s[B_UP] = 1'b1;
    end else if (press_q[B_DN]) begin
      ev_s[B_DN] = 1'b1;
    end else if (press_q[B_LT]) begin
      ev_s[B_LT] = 1'b1;
    end else if (press_q[B_RT]) begin
      ev_s[B_RT] = 1'b1;
    end else begin
      ev_s = 6'b000000;
    end
  end

  // Cursor movement and selection/request FSM next state.
  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    select_loc_d = select_loc_q;
    sel_active_d = sel_active_q;
    move_valid_d = move_valid_q;
    move_from_d  = move_from_q;
    move_to_d    = move_to_q;

    if (ev_s[B_UP]) begin
      cursor_d = {cursor_q[5:3], step_inc(cursor_q[2:0])};
    end else if (ev_s[B_DN]) begin
      cursor_d = {cursor_q[5:3], step_dec(cursor_q[2:0])};
    end else if (ev_s[B_LT]) begin
      cursor_d = {step_dec(cursor_q[5:3]), cursor_q[2:0]};
    end else if (ev_s[B_RT]) begin
      cursor_d = {step_inc(cursor_q[5:3]), cursor_q[2:0]};
    end else begin
      cursor_d = cursor_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ev_s[B_SEL] && own_sq(serialized_board, cursor_q, turn)) begin
          state_d      = ST_SELECTED;
          select_loc_d = cursor_q;
          sel_active_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECTED: begin
        if (ev_s[B_CAN] || (ev_s[B_SEL] && (cursor_q == select_loc_q))) begin
          state_d      = ST_IDLE;
          sel_active_d = 1'b0;
        end else if (ev_s[B_SEL] && own_sq(serialized_board, cursor_q, turn)) begin
          select_loc_d = cursor_q;
        end else if (ev_s[B_SEL] && legal_sq(legal_move, cursor_q)) begin
          state_d      = ST_REQUEST;
          move_from_d  = select_loc_q;
          move_to_d    = cursor_q;
          move_valid_d = 1'b1;
        end else begin
          state_d = ST_SELECTED;
        end
      end
      ST_REQUEST: begin
        if (move_valid_q && move_ready) begin
          state_d      = ST_IDLE;
          move_valid_d = 1'b0;
          sel_active_d = 1'b0;
        end else begin
          state_d = ST_REQUEST;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        move_valid_d = 1'b0;
        sel_active_d = 1'b0;
      end
    endcase
  end

  // Input synchronizers, debounce state and press pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
      lvl_q   <= 6'h00;
      press_q <= 6'h00;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Registered FSM state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cursor_q     <= RESET_CURSOR;
      select_loc_q <= 6'o00;
      sel_active_q <= 1'b0;
      move_valid_q <= 1'b0;
      move_from_q  <= 6'o00;
      move_to_q    <= 6'o00;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      select_loc_q <= select_loc_d;
      sel_active_q <= sel_active_d;
      move_valid_q <= move_valid_d;
      move_from_q  <= move_from_d;
      move_to_q    <= move_to_d;
    end
  end

  assign cursor_loc = cursor_q;
  assign select_loc = select_loc_q;
  assign sel_active = sel_active_q;
  assign move_valid = move_valid_q;
  assign move_from  = move_from_q;
  assign move_to    = move_to_q;

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Directed bench for cursor_select_ctrl: a saturating and a wrapping instance share all inputs.
module tb_cursor_select_ctrl;

  logic         clk;
  logic         rst;
  logic [5:0]   btn_n;
  logic         turn;
  logic [191:0] serialized_board;
  logic [27:0]  legal_move;
  logic         move_ready;

  logic [5:0] cur0, sloc0, from0, to0;
  logic       sact0, mv0;
  logic [5:0] cur1, sloc1, from1, to1;
  logic       sact1, mv1;

  int n_cmp = 0;
  int n_bad = 0;

  cursor_select_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .WRAP(1'b0), .RESET_CURSOR(6'o00)) dut0 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .turn(turn), .serialized_board(serialized_board),
    .legal_move(legal_move), .cursor_loc(cur0), .select_loc(sloc0), .sel_active(sact0),
    .move_valid(mv0), .move_from(from0), .move_to(to0), .move_ready(move_ready)
  );

  cursor_select_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .WRAP(1'b1), .RESET_CURSOR(6'o00)) dut1 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .turn(turn), .serialized_board(serialized_board),
    .legal_move(legal_move), .cursor_loc(cur1), .select_loc(sloc1), .sel_active(sact1),
    .move_valid(mv1), .move_from(from1), .move_to(to1), .move_ready(move_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] mask;
    int         reps;
    logic [5:0] exp0;
    logic [5:0] exp1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %o expected %o", nm, act, exp);
    end
  endtask

  task automatic press(input logic [5:0] mask);
    @(negedge clk);
    btn_n = ~mask;
    repeat (10) @(negedge clk);
    btn_n = 6'h3F;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{6'b000001, 6, 6'o07, 6'o07};
    tbl[1] = '{6'b001000, 7, 6'o77, 6'o77};
    tbl[2] = '{6'b000001, 1, 6'o77, 6'o70};
    tbl[3] = '{6'b001000, 1, 6'o77, 6'o00};
    tbl[4] = '{6'b000010, 1, 6'o76, 6'o07};
    tbl[5] = '{6'b000100, 1, 6'o66, 6'o77};
    tbl[6] = '{6'b001000, 1, 6'o76, 6'o07};
    tbl[7] = '{6'b000010, 2, 6'o74, 6'o05};

    rst = 1'b0;
    btn_n = 6'h3F;
    turn = 1'b1;
    serialized_board = '0;
    legal_move = '0;
    move_ready = 1'b0;
    #1;
    chk("reset_cursor", cur0, 6'o00);
    chk("reset_select_loc", sloc0, 6'o00);
    chk("reset_sel_active", 6'(sact0), 6'd0);
    chk("reset_move_valid", 6'(mv0), 6'd0);
    chk("reset_move_from", from0, 6'o00);
    chk("reset_move_to", to0, 6'o00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Too-short press must be rejected.
    btn_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    btn_n[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("short_press", cur0, 6'o00);

    press(6'b000001);
    chk("long_press_w0", cur0, 6'o01);
    chk("long_press_w1", cur1, 6'o01);

    for (int i = 0; i < 12; i++) begin
      btn_n[0] = ~btn_n[0];
      repeat (2) @(negedge clk);
    end
    btn_n = 6'h3F;
    repeat (12) @(negedge clk);
    chk("chatter", cur0, 6'o01);

    for (int v = 0; v < 8; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        press(tbl[v].mask);
      end
      chk($sformatf("vec%0d_w0", v), cur0, tbl[v].exp0);
      chk($sformatf("vec%0d_w1", v), cur1, tbl[v].exp1);
    end

    // Selection scenarios: red man at 6'o22, white man at 6'o44, red to move.
    do_reset();
    chk("rst2_cursor", cur0, 6'o00);
    serialized_board[54 +: 3]  = 3'b110;
    serialized_board[108 +: 3] = 3'b100;
    press(6'b001000); press(6'b001000); press(6'b000001); press(6'b000001);
    chk("cursor_22", cur0, 6'o22);
    press(6'b010000);
    chk("sel_own_active", 6'(sact0), 6'd1);
    chk("sel_own_loc", sloc0, 6'o22);

    press(6'b001000); press(6'b001000); press(6'b000001); press(6'b000001);
    press(6'b010000);
    chk("sel_white_active", 6'(sact0), 6'd1);
    chk("sel_white_loc", sloc0, 6'o22);
    chk("sel_white_nomove", 6'(mv0), 6'd0);
    press(6'b100000);
    chk("cancel_active", 6'(sact0), 6'd0);

    press(6'b000100); press(6'b000100); press(6'b000010); press(6'b000010);
    press(6'b010000);
    chk("resel_active", 6'(sact0), 6'd1);
    legal_move[20:14] = 7'b1011011;
    press(6'b001000); press(6'b000001);
    chk("cursor_33", cur0, 6'o33);
    press(6'b010000);
    chk("req_valid", 6'(mv0), 6'd1);
    chk("req_from", from0, 6'o22);
    chk("req_to", to0, 6'o33);

    press(6'b100000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", c), 6'(mv0), 6'd1);
    end
    chk("hold_from", from0, 6'o22);
    chk("hold_to", to0, 6'o33);
    chk("hold_sel_active", 6'(sact0), 6'd1);

    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    chk("hs_valid", 6'(mv0), 6'd0);
    chk("hs_sel_active", 6'(sact0), 6'd0);
    repeat (3) @(negedge clk);
    chk("hs_stays_low", 6'(mv0), 6'd0);

    // Simultaneous select and up: select wins, up is dropped.
    press(6'b000100); press(6'b000010);
    press(6'b010001);
    chk("prio_cursor", cur0, 6'o22);
    chk("prio_sel_active", 6'(sact0), 6'd1);
    chk("prio_sel_loc", sloc0, 6'o22);

    press(6'b001000); press(6'b000001); press(6'b010000);
    chk("req2_valid", 6'(mv0), 6'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", 6'(mv0), 6'd0);
    chk("async_sel_active", 6'(sact0), 6'd0);
    chk("async_cursor", cur0, 6'o00);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
